// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the boot-time instruction loader.
package instr_loader_pkg;

    typedef enum logic [2:0] {
        ST_HDR,
        ST_HI,
        ST_LO,
        ST_WR,
        ST_CHK,
        ST_RUN,
        ST_ERR
    } state_t;

    localparam int INSTR_BYTES      = 2;
    localparam bit N_ZERO_MEANS_MAX = 1'b1;

endpackage

// File: rtl/instr_loader.sv
// Boot loader: assembles big-endian words from a byte stream into imem,
// verifies an XOR checksum, then releases the processor.
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 8 * INSTR_BYTES
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                rx_valid,
    input  logic [7:0]          rx_data,
    output logic                rx_ready,
    input  logic                load_req,
    output logic                imem_we,
    output logic [ADDR_W-1:0]   imem_addr,
    output logic [INSTR_W-1:0]  imem_wdata,
    output logic                cpu_run,
    output logic                load_done,
    output logic                load_error,
    output logic [ADDR_W:0]     word_count
);

    state_t               r_state;
    logic [ADDR_W:0]      r_n;
    logic [ADDR_W:0]      r_wcount;
    logic [ADDR_W-1:0]    r_ptr;
    logic [7:0]           r_csum;
    logic [7:0]           r_hi;
    logic                 r_rdy;
    logic                 r_we;
    logic [ADDR_W-1:0]    r_addr;
    logic [INSTR_W-1:0]   r_wdata;
    logic                 r_run;
    logic                 r_done;
    logic                 r_err;

    logic                 w_take;
    logic [ADDR_W:0]      w_hdr_n;
    logic [ADDR_W:0]      w_wcount_nxt;

    assign w_take       = rx_valid && r_rdy;
    assign w_wcount_nxt = r_wcount + {{ADDR_W{1'b0}}, 1'b1};

    // A zero header encodes a full memory image of 2^ADDR_W words.
    assign w_hdr_n = (N_ZERO_MEANS_MAX && rx_data == 8'd0)
                   ? {1'b1, {ADDR_W{1'b0}}}
                   : (ADDR_W+1)'(rx_data);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_HDR;
            r_n      <= '0;
            r_wcount <= '0;
            r_ptr    <= '0;
            r_csum   <= '0;
            r_hi     <= '0;
            r_rdy    <= 1'b1;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_run    <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_we <= 1'b0;
            unique case (r_state)
                ST_HDR: begin
                    if (w_take) begin
                        r_n     <= w_hdr_n;
                        r_state <= ST_HI;
                    end
                end
                ST_HI: begin
                    if (w_take) begin
                        r_hi    <= rx_data;
                        r_csum  <= r_csum ^ rx_data;
                        r_state <= ST_LO;
                    end
                end
                ST_LO: begin
                    if (w_take) begin
                        r_csum  <= r_csum ^ rx_data;
                        r_we    <= 1'b1;
                        r_addr  <= r_ptr;
                        r_wdata <= INSTR_W'({r_hi, rx_data});
                        r_rdy   <= 1'b0;
                        r_state <= ST_WR;
                    end
                end
                ST_WR: begin
                    r_ptr    <= r_ptr + {{(ADDR_W-1){1'b0}}, 1'b1};
                    r_wcount <= w_wcount_nxt;
                    r_rdy    <= 1'b1;
                    r_state  <= (w_wcount_nxt == r_n) ? ST_CHK : ST_HI;
                end
                ST_CHK: begin
                    if (w_take) begin
                        r_rdy <= 1'b0;
                        if (rx_data == r_csum) begin
                            r_run   <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= ST_RUN;
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= ST_ERR;
                        end
                    end
                end
                ST_RUN, ST_ERR: begin
                    if (load_req) begin
                        r_ptr    <= '0;
                        r_wcount <= '0;
                        r_csum   <= '0;
                        r_run    <= 1'b0;
                        r_done   <= 1'b0;
                        r_err    <= 1'b0;
                        r_rdy    <= 1'b1;
                        r_state  <= ST_HDR;
                    end
                end
                default: begin
                    r_rdy   <= 1'b1;
                    r_state <= ST_HDR;
                end
            endcase
        end
    end

    assign rx_ready   = r_rdy;
    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign cpu_run    = r_run;
    assign load_done  = r_done;
    assign load_error = r_err;
    assign word_count = r_wcount;

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: directed streams plus randomized
// loads compared against a queue-based stream model.
module tb_instr_loader;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        load_req = 1'b0;
    logic        rx_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [15:0] imem_wdata;
    logic        cpu_run;
    logic        load_done;
    logic        load_error;
    logic [8:0]  word_count;

    int n_checks = 0;
    int n_pass   = 0;
    int stalls   = 0;

    logic [7:0]  tx_q[$];
    logic [7:0]  wa_q[$];
    logic [15:0] wd_q[$];

    instr_loader dut (
        .clock      (clock),
        .reset      (reset),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .load_req   (load_req),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_run    (cpu_run),
        .load_done  (load_done),
        .load_error (load_error),
        .word_count (word_count)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (reset && imem_we) begin
            wa_q.push_back(imem_addr);
            wd_q.push_back(imem_wdata);
        end
    end

    function automatic logic [7:0] model_xor();
        logic [7:0] x = 8'd0;
        foreach (tx_q[i]) x ^= tx_q[i];
        return x;
    endfunction

    function automatic int model_bad_writes(input int n);
        int bad = 0;
        for (int i = 0; i < n; i++) begin
            if (i >= wa_q.size()) bad++;
            else if (wa_q[i] !== 8'(i % 256) ||
                     wd_q[i] !== {tx_q[2*i], tx_q[2*i+1]}) bad++;
        end
        return bad;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        while (!rx_ready && t < 16) begin
            @(negedge clock);
            t++;
            stalls++;
        end
        if (t >= 16) begin
            n_checks++;
            $display("FAIL send_byte_timeout byte=%h rx_ready=%b", b, rx_ready);
        end
        @(negedge clock);
    endtask

    task automatic drive_load(input logic [7:0] hdr, input logic [7:0] chk);
        wa_q.delete();
        wd_q.delete();
        stalls = 0;
        send_byte(hdr);
        foreach (tx_q[i]) send_byte(tx_q[i]);
        send_byte(chk);
        rx_valid = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic pulse_req();
        load_req = 1'b1;
        @(negedge clock);
        load_req = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        rx_valid = 1'b0;
        repeat (2) @(negedge clock);
        n_checks++; if (rx_ready !== 1'b1) $display("FAIL rst_rx_ready got=%b exp=1", rx_ready); else n_pass++;
        n_checks++; if (imem_we !== 1'b0) $display("FAIL rst_we got=%b exp=0", imem_we); else n_pass++;
        n_checks++; if (imem_addr !== 8'd0) $display("FAIL rst_addr got=%h exp=0", imem_addr); else n_pass++;
        n_checks++; if (imem_wdata !== 16'd0) $display("FAIL rst_wdata got=%h exp=0", imem_wdata); else n_pass++;
        n_checks++; if (cpu_run !== 1'b0) $display("FAIL rst_run got=%b exp=0", cpu_run); else n_pass++;
        n_checks++; if (load_done !== 1'b0) $display("FAIL rst_done got=%b exp=0", load_done); else n_pass++;
        n_checks++; if (load_error !== 1'b0) $display("FAIL rst_err got=%b exp=0", load_error); else n_pass++;
        n_checks++; if (word_count !== 9'd0) $display("FAIL rst_wc got=%0d exp=0", word_count); else n_pass++;
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_directed();
        pulse_req();
        tx_q = '{8'h12, 8'h34, 8'hAB, 8'hCD};
        drive_load(8'h02, 8'h40);
        n_checks++; if (wa_q.size() !== 2) $display("FAIL dir_nwr got=%0d exp=2", wa_q.size()); else n_pass++;
        n_checks++; if (wa_q[0] !== 8'd0 || wd_q[0] !== 16'h1234) $display("FAIL dir_w0 got=%h:%h exp=00:1234", wa_q[0], wd_q[0]); else n_pass++;
        n_checks++; if (wa_q[1] !== 8'd1 || wd_q[1] !== 16'hABCD) $display("FAIL dir_w1 got=%h:%h exp=01:abcd", wa_q[1], wd_q[1]); else n_pass++;
        n_checks++; if (word_count !== 9'd2) $display("FAIL dir_wc got=%0d exp=2", word_count); else n_pass++;
        n_checks++; if ({cpu_run, load_done, load_error} !== 3'b110) $display("FAIL dir_status got=%b exp=110", {cpu_run, load_done, load_error}); else n_pass++;
    endtask

    task automatic test_bad_checksum();
        pulse_req();
        tx_q = '{8'h12, 8'h34, 8'hAB, 8'hCD};
        drive_load(8'h02, 8'h41);
        n_checks++; if (model_bad_writes(2) != 0 || wa_q.size() != 2) $display("FAIL bad_writes got=%0d exp=2 ok", wa_q.size()); else n_pass++;
        n_checks++; if ({cpu_run, load_done, load_error} !== 3'b001) $display("FAIL bad_status got=%b exp=001", {cpu_run, load_done, load_error}); else n_pass++;
        n_checks++; if (rx_ready !== 1'b0) $display("FAIL bad_rdy got=%b exp=0", rx_ready); else n_pass++;
        pulse_req();
        n_checks++; if ({cpu_run, load_done, load_error} !== 3'b000) $display("FAIL bad_req_status got=%b exp=000", {cpu_run, load_done, load_error}); else n_pass++;
        n_checks++; if (rx_ready !== 1'b1 || word_count !== 9'd0) $display("FAIL bad_req_hdr got=%b/%0d exp=1/0", rx_ready, word_count); else n_pass++;
    endtask

    task automatic test_back_to_back();
        pulse_req();
        tx_q.delete();
        repeat (6) tx_q.push_back(8'($urandom));
        drive_load(8'h03, model_xor());
        n_checks++; if (stalls != 3) $display("FAIL b2b_stalls got=%0d exp=3", stalls); else n_pass++;
        n_checks++; if (wa_q.size() != 3 || model_bad_writes(3) != 0) $display("FAIL b2b_writes got=%0d bad=%0d exp=3 bad=0", wa_q.size(), model_bad_writes(3)); else n_pass++;
        n_checks++; if (cpu_run !== 1'b1) $display("FAIL b2b_run got=%b exp=1", cpu_run); else n_pass++;
    endtask

    task automatic test_full();
        pulse_req();
        tx_q.delete();
        repeat (512) tx_q.push_back(8'h5A);
        drive_load(8'h00, 8'h00);
        n_checks++; if (wa_q.size() != 256) $display("FAIL full_nwr got=%0d exp=256", wa_q.size()); else n_pass++;
        n_checks++; if (model_bad_writes(256) != 0) $display("FAIL full_writes got=%0d bad exp=0", model_bad_writes(256)); else n_pass++;
        n_checks++; if (word_count !== 9'd256) $display("FAIL full_wc got=%0d exp=256", word_count); else n_pass++;
        n_checks++; if ({cpu_run, load_done, load_error} !== 3'b110) $display("FAIL full_status got=%b exp=110", {cpu_run, load_done, load_error}); else n_pass++;
    endtask

    task automatic test_random();
        for (int it = 0; it < 20; it++) begin
            int n;
            bit good;
            logic [7:0] chk;
            n = $urandom_range(1, 10);
            good = ($urandom_range(0, 3) != 0);
            tx_q.delete();
            repeat (2 * n) tx_q.push_back(8'($urandom));
            chk = good ? model_xor() : model_xor() ^ 8'($urandom_range(1, 255));
            pulse_req();
            drive_load(8'(n), chk);
            n_checks++; if (wa_q.size() != n || model_bad_writes(n) != 0) $display("FAIL rnd_writes it=%0d got=%0d exp=%0d", it, wa_q.size(), n); else n_pass++;
            n_checks++; if (word_count !== 9'(n)) $display("FAIL rnd_wc it=%0d got=%0d exp=%0d", it, word_count, n); else n_pass++;
            n_checks++; if ({cpu_run, load_done, load_error} !== {good, good, !good}) $display("FAIL rnd_status it=%0d got=%b exp=%b", it, {cpu_run, load_done, load_error}, {good, good, !good}); else n_pass++;
        end
    endtask

    task automatic test_reset_midload();
        pulse_req();
        tx_q.delete();
        repeat (8) tx_q.push_back(8'($urandom_range(1, 255)));
        send_byte(8'h04);
        for (int i = 0; i < 3; i++) send_byte(tx_q[i]);
        reset = 1'b0;
        #1;
        n_checks++; if (rx_ready !== 1'b1) $display("FAIL mid_rdy got=%b exp=1", rx_ready); else n_pass++;
        n_checks++; if (imem_we !== 1'b0 || imem_addr !== 8'd0) $display("FAIL mid_we_addr got=%b/%h exp=0/00", imem_we, imem_addr); else n_pass++;
        n_checks++; if (imem_wdata !== 16'd0) $display("FAIL mid_wdata got=%h exp=0000", imem_wdata); else n_pass++;
        n_checks++; if (word_count !== 9'd0) $display("FAIL mid_wc got=%0d exp=0", word_count); else n_pass++;
        n_checks++; if ({cpu_run, load_done, load_error} !== 3'b000) $display("FAIL mid_status got=%b exp=000", {cpu_run, load_done, load_error}); else n_pass++;
        rx_valid = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        tx_q = '{8'hC3, 8'h3C};
        drive_load(8'h01, model_xor());
        n_checks++; if (wa_q.size() != 1 || wa_q[0] !== 8'd0 || wd_q[0] !== 16'hC33C) $display("FAIL mid_reload got=%0d writes exp=1 at 00=c33c", wa_q.size()); else n_pass++;
        n_checks++; if (cpu_run !== 1'b1 || word_count !== 9'd1) $display("FAIL mid_run got=%b/%0d exp=1/1", cpu_run, word_count); else n_pass++;
    endtask

    task automatic test_run_ignore();
        int bad = 0;
        wa_q.delete();
        rx_valid = 1'b1;
        rx_data  = 8'hFF;
        repeat (5) begin
            @(negedge clock);
            if (rx_ready !== 1'b0) bad++;
        end
        rx_valid = 1'b0;
        @(negedge clock);
        n_checks++; if (bad != 0) $display("FAIL run_rdy got=%0d high cycles exp=0", bad); else n_pass++;
        n_checks++; if (wa_q.size() != 0) $display("FAIL run_nowrite got=%0d exp=0", wa_q.size()); else n_pass++;
        n_checks++; if (cpu_run !== 1'b1 || word_count !== 9'd1) $display("FAIL run_hold got=%b/%0d exp=1/1", cpu_run, word_count); else n_pass++;
    endtask

    initial begin
        @(negedge clock);
        test_reset();
        test_directed();
        test_bad_checksum();
        test_back_to_back();
        test_full();
        test_random();
        test_reset_midload();
        test_run_ignore();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_loader.md
# instr_loader

Boot-time instruction loader that sits directly upstream of the pipelined processor's IF stage. It accepts a byte stream from a host link (UART receiver or JTAG bridge) and assembles big-endian 16-bit instructions. It writes them sequentially into instruction memory from address 0, checks an XOR checksum, and only then releases the processor to run. The processor is held stopped throughout loading and after any checksum failure.

## Interface
- `ADDR_W`, 8, instruction memory address width (matches the 8-bit program counter)
- `INSTR_W`, 16, instruction width; fixed at 2 bytes per word
- `clock`  in  1  processor clock; all state changes on its rising edge
- `reset`  in  1  asynchronous, active-low reset for the whole block
- `rx_valid`  in  1  host byte available
- `rx_data`  in  8  host byte
- `rx_ready`  out  1  loader can accept a byte; a byte transfers when `rx_valid && rx_ready`
- `load_req`  in  1  single-cycle pulse; restarts loading from the RUN or ERR state
- `imem_we`  out  1  instruction memory write strobe
- `imem_addr`  out  ADDR_W  instruction memory write address
- `imem_wdata`  out  INSTR_W  instruction memory write data
- `cpu_run`  out  1  high means processor released; low means processor held in reset
- `load_done`  out  1  loading completed and checksum passed (level)
- `load_error`  out  1  checksum mismatch (level)
- `word_count`  out  ADDR_W+1  number of words written in the current load

## Operation
- Stream format: header byte N, then 2·N instruction bytes (high byte first), then one checksum byte. The checksum is the XOR of every instruction byte; the header is not included.
- N=0 means 256 words. The effective count is held internally in ADDR_W+1 bits.
- States and transitions:
  - HDR: accept N; go to HI.
  - HI: accept the high byte, latch it, XOR it into the checksum; go to LO.
  - LO: accept the low byte, XOR it into the checksum; go to WR.
  - WR: pulse `imem_we` with `imem_addr` = write pointer and `imem_wdata` = {hi, lo}. Increment the pointer and `word_count`. Go to CHK if `word_count`+1 == effective N, otherwise go to HI.
  - CHK: accept the checksum byte. Go to RUN if it matches the running XOR, otherwise go to ERR.
  - RUN: `cpu_run`=1 and `load_done`=1. On `load_req`, go to HDR.
  - ERR: `load_error`=1 and `cpu_run`=0. On `load_req`, go to HDR.
- Entering HDR clears the write pointer, `word_count`, the checksum, `load_done` and `load_error`, and sets `cpu_run`=0.
- `rx_ready`=1 only in HDR, HI, LO and CHK. It is 0 in WR, RUN and ERR, and bytes arriving in those states are not consumed.
- The write pointer wraps modulo 2^ADDR_W. With N=256 the final write is to address 255, and no address is written twice.
- `load_req` in HDR, HI, LO, WR or CHK is ignored.

## Timing
- Reset values (asserted asynchronously): state=HDR, `rx_ready`=1, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `cpu_run`=0, `load_done`=0, `load_error`=0, `word_count`=0.
- The low byte is accepted at edge k. `imem_we` is high for exactly the cycle following edge k, with address and data stable during that cycle.
- Per-word throughput is 3 cycles minimum: HI, LO, WR.
- `cpu_run` rises on the edge after the checksum byte is accepted. It falls on the edge after `load_req` is sampled in RUN.
- If `reset` is asserted mid-load, the block returns to HDR immediately. Memory contents already written are left untouched, and the next load overwrites them from address 0.
- `rx_valid` may stay high back-to-back. The loader stalls it only through `rx_ready`.

## Structure
- Shared package `instr_loader_pkg`:
  - state enum (HDR, HI, LO, WR, CHK, RUN, ERR)
  - `INSTR_BYTES`=2
  - `N_ZERO_MEANS_MAX`=1
- Single module with no sub-modules. The checksum accumulator and the word counter are inline registers.
- At top level, `cpu_run` is inverted to drive the processor's reset input. Instruction memory gets a dedicated write port.

## Test plan
- Header 0x02, bytes 12 34 AB CD, checksum 0x40: writes mem[0]=0x1234 and mem[1]=0xABCD, `word_count`=2, `cpu_run`=1, `load_done`=1.
- Same stream with checksum 0x41: both words are written, then ERR with `load_error`=1 and `cpu_run`=0. `load_req` then returns to HDR with `load_error`=0.
- Header 0x00 followed by 512 bytes of 0x5A and checksum 0x00: 256 writes to addresses 0..255, `word_count`=256, RUN.
- `rx_valid` held high continuously: `rx_ready` drops for exactly 1 cycle per word (WR). No byte is lost or duplicated across 3 words.
- `reset` is pulsed low after the 3rd data byte of a 4-word load. All outputs take their reset values immediately. A fresh 1-word load then writes to address 0 and reaches RUN.
- In RUN, `rx_valid`=1 with data 0xFF and no `load_req`: `rx_ready`=0, no write occurs, and `cpu_run` stays 1.
